// File: rtl/ex_mem_pipe_reg_pkg.sv
// pipe_pkg: shared types and widths for the RV32I pipeline stage registers.
//
// Contents:
//   PIPE_XLEN / PIPE_RD_W / PIPE_F3_W / PIPE_RS_W  default field widths
//   result_src_e   writeback result selector (ALU, MEM, PC+4)
//   stage_state_e  occupancy of a two-slot elastic stage register
//   ex_mem_t       EX->MEM payload at the default widths
package pipe_pkg;

    localparam int PIPE_XLEN = 32;
    localparam int PIPE_RD_W = 5;
    localparam int PIPE_F3_W = 3;
    localparam int PIPE_RS_W = 2;

    typedef enum logic [PIPE_RS_W-1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    // EMPTY: nothing held, ONE: main slot valid, TWO: main and skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc_plus4;
        logic [PIPE_XLEN-1:0] alu_result;
        logic [PIPE_XLEN-1:0] write_data;
        logic [PIPE_RD_W-1:0] rd;
        logic [PIPE_F3_W-1:0] funct3;
        result_src_e          result_src;
        logic                 mem_write;
        logic                 reg_write;
    } ex_mem_t;

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_pipe_reg_if: EX->MEM stage link.
//
// Groups the upstream handshake and E-side payload, the downstream handshake
// and M-side payload, and the flush control.
//   slave  : view of the pipeline register itself
//   master : view of the surrounding EX/MEM/hazard logic
interface ex_mem_pipe_reg_if import pipe_pkg::*; #(
    parameter int XLEN = PIPE_XLEN,
    parameter int RD_W = PIPE_RD_W,
    parameter int F3_W = PIPE_F3_W,
    parameter int RS_W = PIPE_RS_W
) ();

    logic            flush;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] ALUResultE;
    logic [XLEN-1:0] WriteDataE;
    logic [RD_W-1:0] RdE;
    logic [F3_W-1:0] funct3E;
    logic [RS_W-1:0] ResultSrcE;
    logic            MemWriteE;
    logic            RegWriteE;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] PCPlus4M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [RD_W-1:0] RdM;
    logic [F3_W-1:0] funct3M;
    logic [RS_W-1:0] ResultSrcM;
    logic            MemWriteM;
    logic            RegWriteM;

    modport slave (
        input  flush, in_valid, PCPlus4E, ALUResultE, WriteDataE, RdE, funct3E,
               ResultSrcE, MemWriteE, RegWriteE, out_ready,
        output in_ready, out_valid, PCPlus4M, ALUResultM, WriteDataM, RdM,
               funct3M, ResultSrcM, MemWriteM, RegWriteM
    );

    modport master (
        output flush, in_valid, PCPlus4E, ALUResultE, WriteDataE, RdE, funct3E,
               ResultSrcE, MemWriteE, RegWriteE, out_ready,
        input  in_ready, out_valid, PCPlus4M, ALUResultM, WriteDataM, RdM,
               funct3M, ResultSrcM, MemWriteM, RegWriteM
    );

endinterface

// File: rtl/ex_mem_pipe_reg_skid.sv
// skid_reg: generic two-slot elastic stage register (main + skid).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           drop every held entry and any same-cycle accept
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (main slot)
//
// in_ready is decoded only from the state register, so there is no
// combinational path from out_ready back to the upstream stage. Payload is
// never cleared except by reset; outputs hold their last value while empty.
module skid_reg import pipe_pkg::*; #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    stage_state_e state, state_next;
    T             skid_q;
    logic         accept, consume;
    logic         load_main_in, load_main_skid, load_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over accept and consume: nothing is loaded, so a squashed
    // instruction never reaches the payload outputs.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next   = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (consume) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_next     = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            skid_q   <= '0;
        end else begin
            if (load_main_in) begin
                out_data <= in_data;
            end else if (load_main_skid) begin
                out_data <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM pipeline register with valid/ready handshake,
// one-entry skid buffer, stall back-pressure and flush.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (priority over flush)
//   bus   ex_mem_pipe_reg_if.slave: flush, E-side handshake/payload,
//         M-side handshake/payload
//
// MemWriteM/RegWriteM are gated by out_valid so a bubble can never write
// memory or the register file, even though the stored bits are held.
module ex_mem_pipe_reg import pipe_pkg::*; #(
    parameter int XLEN = PIPE_XLEN,
    parameter int RD_W = PIPE_RD_W,
    parameter int F3_W = PIPE_F3_W,
    parameter int RS_W = PIPE_RS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_mem_pipe_reg_if.slave     bus
);

    // Same field order as pipe_pkg::ex_mem_t, but sized by this instance's
    // parameters so non-default widths still pass through exactly.
    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [RD_W-1:0] rd;
        logic [F3_W-1:0] funct3;
        logic [RS_W-1:0] result_src;
        logic            mem_write;
        logic            reg_write;
    } payload_t;

    payload_t in_pl, out_pl;

    assign in_pl.pc_plus4   = bus.PCPlus4E;
    assign in_pl.alu_result = bus.ALUResultE;
    assign in_pl.write_data = bus.WriteDataE;
    assign in_pl.rd         = bus.RdE;
    assign in_pl.funct3     = bus.funct3E;
    assign in_pl.result_src = bus.ResultSrcE;
    assign in_pl.mem_write  = bus.MemWriteE;
    assign in_pl.reg_write  = bus.RegWriteE;

    skid_reg #(.T(payload_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_pl),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pl)
    );

    assign bus.PCPlus4M   = out_pl.pc_plus4;
    assign bus.ALUResultM = out_pl.alu_result;
    assign bus.WriteDataM = out_pl.write_data;
    assign bus.RdM        = out_pl.rd;
    assign bus.funct3M    = out_pl.funct3;
    assign bus.ResultSrcM = out_pl.result_src;
    assign bus.MemWriteM  = out_pl.mem_write & bus.out_valid;
    assign bus.RegWriteM  = out_pl.reg_write & bus.out_valid;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: self-checking bench for ex_mem_pipe_reg.
//
// A queue of at most two in-flight entries stands in for the stage; the
// entry at its head (or the last one shown, while empty) is what the M-side
// outputs must carry.
module tb_ex_mem_pipe_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ex_mem_pipe_reg_if bus ();

    ex_mem_pipe_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  rs;
        logic        mw;
        logic        rw;
    } pay_t;

    pay_t        mq[$];
    pay_t        shown = '0;
    logic [31:0] dut_consumed[$];
    int          checks = 0;
    int          failures = 0;

    function automatic pay_t rand_pay();
        pay_t p;
        p.pc4 = $urandom();
        p.alu = $urandom();
        p.wd  = $urandom();
        p.rd  = 5'($urandom_range(0, 31));
        p.f3  = 3'($urandom_range(0, 7));
        p.rs  = 2'($urandom_range(0, 2));
        p.mw  = 1'($urandom_range(0, 1));
        p.rw  = 1'($urandom_range(0, 1));
        return p;
    endfunction

    function automatic pay_t actual();
        pay_t a;
        a.pc4 = bus.PCPlus4M;
        a.alu = bus.ALUResultM;
        a.wd  = bus.WriteDataM;
        a.rd  = bus.RdM;
        a.f3  = bus.funct3M;
        a.rs  = bus.ResultSrcM;
        a.mw  = bus.MemWriteM;
        a.rw  = bus.RegWriteM;
        return a;
    endfunction

    // A bubble never writes; everything else is the held head entry.
    function automatic pay_t expected();
        pay_t e;
        e    = shown;
        e.mw = shown.mw & (mq.size() > 0);
        e.rw = shown.rw & (mq.size() > 0);
        return e;
    endfunction

    task automatic drive(input logic v, input pay_t p, input logic ordy, input logic fl);
        bus.in_valid   = v;
        bus.PCPlus4E   = p.pc4;
        bus.ALUResultE = p.alu;
        bus.WriteDataE = p.wd;
        bus.RdE        = p.rd;
        bus.funct3E    = p.f3;
        bus.ResultSrcE = p.rs;
        bus.MemWriteE  = p.mw;
        bus.RegWriteE  = p.rw;
        bus.out_ready  = ordy;
        bus.flush      = fl;
    endtask

    // One clock: the model reacts to the inputs that were present at the edge.
    task automatic cycle();
        logic acc, con;
        pay_t cur;
        cur.pc4 = bus.PCPlus4E;
        cur.alu = bus.ALUResultE;
        cur.wd  = bus.WriteDataE;
        cur.rd  = bus.RdE;
        cur.f3  = bus.funct3E;
        cur.rs  = bus.ResultSrcE;
        cur.mw  = bus.MemWriteE;
        cur.rw  = bus.RegWriteE;
        acc = bus.in_valid && (mq.size() < 2);
        con = bus.out_ready && (mq.size() > 0);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            dut_consumed.push_back(bus.ALUResultM);
        end
        @(posedge clk);
        if (rst) begin
            mq.delete();
            shown = '0;
        end else if (bus.flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(cur);
            if (mq.size() > 0) shown = mq[0];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, rand_pay(), 1'b1, 1'b0);
        cycle();
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.RegWriteM !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_regwrite: got %0b expected 0", bus.RegWriteM);
        end
        checks++;
        if (actual() !== pay_t'('0)) begin
            failures++;
            $display("[TB] FAIL reset_fields: got %h expected 0", actual());
        end
        rst = 1'b0;
        drive(1'b0, rand_pay(), 1'b0, 1'b0);
        cycle();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got ready=%0b valid=%0b expected ready=1 valid=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_streaming();
        pay_t p;
        for (int i = 0; i < 8; i++) begin
            p = rand_pay();
            p.alu = 32'h100 + 32'(i);
            drive(1'b1, p, 1'b1, 1'b0);
            cycle();
            checks++;
            if (bus.ALUResultM !== 32'h100 + 32'(i) || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stream_%0d: got alu=%h valid=%0b ready=%0b expected alu=%h valid=1 ready=1",
                         i, bus.ALUResultM, bus.out_valid, bus.in_ready, 32'h100 + 32'(i));
            end
            checks++;
            if (actual() !== expected()) begin
                failures++;
                $display("[TB] FAIL stream_model_%0d: got %h expected %h", i, actual(), expected());
            end
        end
        drive(1'b0, rand_pay(), 1'b1, 1'b0);
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ALUResultM !== 32'h107) begin
            failures++;
            $display("[TB] FAIL stream_drain: got valid=%0b alu=%h expected valid=0 alu=107",
                     bus.out_valid, bus.ALUResultM);
        end
    endtask

    task automatic test_stall();
        pay_t pa, pb, pc;
        pa = rand_pay(); pa.alu = 32'h200;
        pb = rand_pay(); pb.alu = 32'h201;
        pc = rand_pay(); pc.alu = 32'h202;
        dut_consumed.delete();
        drive(1'b1, pa, 1'b1, 1'b0);
        cycle();
        drive(1'b1, pb, 1'b0, 1'b0);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.ALUResultM !== 32'h200) begin
            failures++;
            $display("[TB] FAIL stall_a_shown: got ready=%0b alu=%h expected ready=1 alu=200",
                     bus.in_ready, bus.ALUResultM);
        end
        cycle();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.ALUResultM !== 32'h200 || bus.out_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stall_hold_%0d: got ready=%0b valid=%0b alu=%h expected ready=0 valid=1 alu=200",
                         k, bus.in_ready, bus.out_valid, bus.ALUResultM);
            end
            drive(1'b1, pc, (k == 2) ? 1'b1 : 1'b0, 1'b0);
            cycle();
        end
        checks++;
        if (bus.ALUResultM !== 32'h201 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_release: got alu=%h ready=%0b expected alu=201 ready=1",
                     bus.ALUResultM, bus.in_ready);
        end
        cycle();
        checks++;
        if (bus.ALUResultM !== 32'h202 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_c: got alu=%h valid=%0b expected alu=202 valid=1",
                     bus.ALUResultM, bus.out_valid);
        end
        drive(1'b0, pc, 1'b1, 1'b0);
        cycle();
        checks++;
        if (dut_consumed.size() != 3 || dut_consumed[0] !== 32'h200 ||
            dut_consumed[1] !== 32'h201 || dut_consumed[2] !== 32'h202) begin
            failures++;
            $display("[TB] FAIL stall_order: got %p expected 200,201,202", dut_consumed);
        end
    endtask

    task automatic test_flush_accept();
        pay_t px, pf;
        px = rand_pay(); px.alu = 32'h400;
        pf = rand_pay(); pf.alu = 32'hDEAD_0000; pf.mw = 1'b1;
        drive(1'b1, px, 1'b0, 1'b0);
        cycle();
        drive(1'b1, pf, 1'b0, 1'b1);
        cycle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.MemWriteM !== 1'b0 || bus.ALUResultM !== 32'h400) begin
            failures++;
            $display("[TB] FAIL flush_accept: got valid=%0b memwrite=%0b alu=%h expected valid=0 memwrite=0 alu=400",
                     bus.out_valid, bus.MemWriteM, bus.ALUResultM);
        end
        drive(1'b0, pf, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.ALUResultM === 32'hDEAD_0000) begin
                failures++;
                $display("[TB] FAIL flush_leak_%0d: got valid=%0b alu=%h expected valid=0 alu!=dead0000",
                         k, bus.out_valid, bus.ALUResultM);
            end
        end
    endtask

    task automatic test_bubble();
        pay_t pb;
        pb = rand_pay();
        pb.alu = 32'h500; pb.wd = 32'h5A5A_0001; pb.mw = 1'b1; pb.rw = 1'b1;
        drive(1'b1, pb, 1'b1, 1'b0);
        cycle();
        checks++;
        if (bus.MemWriteM !== 1'b1 || bus.RegWriteM !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bubble_live: got mw=%0b rw=%0b expected mw=1 rw=1", bus.MemWriteM, bus.RegWriteM);
        end
        drive(1'b0, pb, 1'b1, 1'b0);
        cycle();
        checks++;
        if (bus.MemWriteM !== 1'b0 || bus.RegWriteM !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.WriteDataM !== 32'h5A5A_0001) begin
            failures++;
            $display("[TB] FAIL bubble_gate: got mw=%0b rw=%0b valid=%0b wd=%h expected mw=0 rw=0 valid=0 wd=5a5a0001",
                     bus.MemWriteM, bus.RegWriteM, bus.out_valid, bus.WriteDataM);
        end
    endtask

    task automatic test_reset_in_two();
        pay_t pp, pq;
        pp = rand_pay(); pp.alu = 32'h300;
        pq = rand_pay(); pq.alu = 32'h301;
        drive(1'b1, pp, 1'b0, 1'b0);
        cycle();
        drive(1'b1, pq, 1'b0, 1'b0);
        cycle();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL two_full: got ready=%0b valid=%0b expected ready=0 valid=1",
                     bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        drive(1'b0, pp, 1'b0, 1'b0);
        cycle();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ALUResultM !== 32'h0) begin
            failures++;
            $display("[TB] FAIL two_reset: got valid=%0b ready=%0b alu=%h expected valid=0 ready=1 alu=0",
                     bus.out_valid, bus.in_ready, bus.ALUResultM);
        end
        drive(1'b0, pp, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.ALUResultM === 32'h300 || bus.ALUResultM === 32'h301) begin
                failures++;
                $display("[TB] FAIL two_lost_%0d: got valid=%0b alu=%h expected valid=0 alu=0",
                         k, bus.out_valid, bus.ALUResultM);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(($urandom_range(0, 9) < 7), rand_pay(), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 15) == 0));
            checks++;
            if (bus.in_ready !== (mq.size() < 2) || bus.out_valid !== (mq.size() > 0)) begin
                failures++;
                $display("[TB] FAIL rand_hs_%0d: got ready=%0b valid=%0b expected ready=%0b valid=%0b",
                         i, bus.in_ready, bus.out_valid, (mq.size() < 2), (mq.size() > 0));
            end
            cycle();
            checks++;
            if (actual() !== expected()) begin
                failures++;
                $display("[TB] FAIL rand_out_%0d: got %h expected %h", i, actual(), expected());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_stall();
        test_flush_accept();
        test_bubble();
        test_reset_in_two();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
